// File: rtl/cache_pkg.sv
// cache_pkg: controller state encoding and geometry helpers for the direct-mapped read cache
package cache_pkg;
  typedef enum logic [2:0] {FLUSH, IDLE, LOOKUP, MREQ, REFILL, RESP} state_t;
  function automatic int tag_w(input int addr_w, input int index_w, input int offset_w);
    return addr_w - index_w - offset_w;
  endfunction
  function automatic int lines(input int index_w);
    return 1 << index_w;
  endfunction
  function automatic int words(input int offset_w);
    return 1 << offset_w;
  endfunction
endpackage

// File: rtl/cache_data_ram.sv
// cache_data_ram: single-port synchronous-read word store backing all cache lines
module cache_data_ram #(
  parameter int DATA_W = 32,
  parameter int AW = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/param_cache.sv
// param_cache: direct-mapped read cache with block refill, flush walk and hit/miss statistics
module param_cache
  import cache_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 15,
  parameter int OFFSET_W = 2,
  parameter int INDEX_W = 10,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              hit,
  output logic              miss,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  localparam int TAG_W = tag_w(ADDR_W, INDEX_W, OFFSET_W);
  localparam int LINES = lines(INDEX_W);
  localparam int WORDS = words(OFFSET_W);
  state_t state, state_n;
  logic [ADDR_W-1:0] req_addr;
  logic [INDEX_W-1:0] fidx;
  logic [OFFSET_W-1:0] beat;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [DATA_W-1:0] rbuf, ram_q;
  logic [INDEX_W+OFFSET_W-1:0] ram_addr;
  logic [TAG_W-1:0] req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [OFFSET_W-1:0] req_off;
  logic lookup_hit, last_beat, accept;
  assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx = req_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign req_off = req_addr[OFFSET_W-1:0];
  assign lookup_hit = valid[req_idx] && tags[req_idx] == req_tag;
  assign last_beat = state == REFILL && mem_rvalid && beat == OFFSET_W'(WORDS - 1);
  assign accept = state == IDLE && !flush && cpu_req;
  assign cpu_ready = state == IDLE;
  // The read is launched from the live cpu_addr in IDLE so the word is ready during LOOKUP
  assign ram_addr = state == IDLE   ? cpu_addr[OFFSET_W+INDEX_W-1:0] :
                    state == REFILL ? {req_idx, beat} : req_addr[OFFSET_W+INDEX_W-1:0];
  cache_data_ram #(.DATA_W(DATA_W), .AW(INDEX_W + OFFSET_W)) u_ram (
    .clk  (clk),
    .we   (state == REFILL && mem_rvalid),
    .addr (ram_addr),
    .wdata(mem_rdata),
    .rdata(ram_q)
  );
  always_comb begin
    state_n = state;
    case (state)
      FLUSH:   state_n = fidx == '1 ? IDLE : FLUSH;
      IDLE:    state_n = flush ? FLUSH : cpu_req ? LOOKUP : IDLE;
      LOOKUP:  state_n = lookup_hit ? IDLE : MREQ;
      MREQ:    state_n = mem_ready ? REFILL : MREQ;
      REFILL:  state_n = last_beat ? RESP : REFILL;
      RESP:    state_n = IDLE;
      default: state_n = FLUSH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= FLUSH;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fidx <= '0;
      beat <= '0;
      cpu_rvalid <= 1'b0;
      hit <= 1'b0;
      miss <= 1'b0;
      mem_req <= 1'b0;
      cpu_rdata <= '0;
      mem_addr <= '0;
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      cpu_rvalid <= (state == LOOKUP && lookup_hit) || state == RESP;
      hit <= state == LOOKUP && lookup_hit;
      miss <= state == LOOKUP && !lookup_hit;
      mem_req <= state == MREQ && mem_ready;
      if (state == FLUSH) fidx <= fidx + 1'b1;
      if (state == LOOKUP && lookup_hit) begin
        hit_cnt <= hit_cnt + 1'b1;
        cpu_rdata <= ram_q;
      end
      if (state == LOOKUP && !lookup_hit) miss_cnt <= miss_cnt + 1'b1;
      if (state == MREQ && mem_ready) begin
        mem_addr <= {req_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        beat <= '0;
      end
      if (state == REFILL && mem_rvalid) beat <= beat + 1'b1;
      // Requested word is captured in flight so RESP never re-reads the RAM
      if (state == REFILL && mem_rvalid && beat == req_off) rbuf <= mem_rdata;
      if (state == RESP) cpu_rdata <= rbuf;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) req_addr <= cpu_addr;
  end
  always_ff @(posedge clk) begin
    if (rst_n && state == FLUSH) valid[fidx] <= 1'b0;
    else if (rst_n && last_beat) begin
      valid[req_idx] <= 1'b1;
      tags[req_idx] <= req_tag;
    end
  end
endmodule
